// File: rtl/vfd_pkg.sv
// Shared definitions for the VFD scan capture and the downstream renderer:
// sizes, the MCU port-to-grid/plate mapping and the capture FSM state type.
package vfd_pkg;

    localparam int NGRID  = 10;
    localparam int NPLATE = 17;
    // Packed MCU ports, LSB first: {I[2:0], H[3:0], G[3:0], F, E, D, C}
    localparam int NPORT  = 27;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } vfd_state_e;

    // grid[9:0] = {I, H, G[2:0]}
    function automatic logic [NGRID-1:0] port_grid(input logic [NPORT-1:0] ports);
        return {ports[26:24], ports[23:20], ports[18:16]};
    endfunction

    // plate[16:0] = {G[3], F, E, D, C}
    function automatic logic [NPLATE-1:0] port_plate(input logic [NPORT-1:0] ports);
        return {ports[19], ports[15:0]};
    endfunction

    // Index of the highest set grid bit; only meaningful when one bit is set.
    function automatic logic [3:0] grid_index(input logic [NGRID-1:0] grid);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NGRID; i++) begin
            if (grid[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vfd_persist_grid_slot.sv
// One grid's committed plate mask with its decay age. A commit loads the
// mask and restarts the age; each tick ages it until DECAY, where it blanks.
module grid_slot
    import vfd_pkg::*;
#(
    parameter int DECAY = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic              tick,
    input  logic [NPLATE-1:0] acc,
    output logic [NPLATE-1:0] mask
);

    localparam int AW = $clog2(DECAY + 1);

    logic [NPLATE-1:0] mask_q, mask_d;
    logic [AW-1:0]     age_q, age_d;

    // Commit has priority over a coincident tick so a refresh never blanks.
    always_comb begin
        mask_d = mask_q;
        age_d  = age_q;
        if (commit) begin
            mask_d = acc;
            age_d  = '0;
        end else if (tick && (age_q < AW'(DECAY))) begin
            age_d = age_q + AW'(1);
            if (age_d == AW'(DECAY)) mask_d = '0;
        end
    end

    // Slot state; reset leaves every grid already decayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            age_q  <= AW'(DECAY);
        end else begin
            mask_q <= mask_d;
            age_q  <= age_d;
        end
    end

    assign mask = mask_q;

endmodule

// File: rtl/vfd_persist.sv
// Captures the MCU's multiplexed VFD scan into per-grid persistent plate
// masks. Each grid strobe is accumulated and committed only when the strobe
// ends, so readers never see a partial mask. Masks fade after DECAY ticks
// without refresh. dbg_state = {in ACC, grid being accumulated (0 in IDLE)}.
module vfd_persist
    import vfd_pkg::*;
#(
    parameter int TICK_DIV = 20000,
    parameter int DECAY    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        C,
    input  logic [3:0]        D,
    input  logic [3:0]        E,
    input  logic [3:0]        F,
    input  logic [3:0]        G,
    input  logic [3:0]        H,
    input  logic [2:0]        I,
    input  logic [3:0]        rd_grid,
    output logic [NPLATE-1:0] rd_mask,
    output logic              frame_strobe,
    output logic [7:0]        glitch_cnt,
    output logic [4:0]        dbg_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [NPORT-1:0]  sync1_q, sync2_q;
    logic [NGRID-1:0]  grid_s;
    logic [NPLATE-1:0] plate_s;
    logic              grid_any, grid_multi;
    logic [3:0]        grid_idx;

    vfd_state_e        state_q, state_d;
    logic [3:0]        cur_q, cur_d;
    logic [NPLATE-1:0] acc_q, acc_d;
    logic [7:0]        glitch_q, glitch_d;
    logic [3:0]        last_q, last_d;
    logic              frame_q, frame_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [NPLATE-1:0] rd_mask_q, rd_mask_d;
    logic              tick, commit;
    logic [NGRID-1:0]  commit_vec;
    logic [NPLATE-1:0] mask_w [NGRID];

    // Two-flop synchronizer on every MCU port bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {I, H, G, F, E, D, C};
            sync2_q <= sync1_q;
        end
    end

    assign grid_s     = port_grid(sync2_q);
    assign plate_s    = port_plate(sync2_q);
    assign grid_any   = |grid_s;
    assign grid_multi = |(grid_s & (grid_s - NGRID'(1)));
    assign grid_idx   = grid_index(grid_s);

    // Decay prescaler: tick marks the wrap cycle.
    always_comb begin
        tick   = (pcnt_q == PW'(TICK_DIV - 1));
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end

    // Capture FSM: accumulate while one grid stays lit, commit when it ends.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        acc_d    = acc_q;
        glitch_d = glitch_q;
        commit   = 1'b0;
        if (grid_multi) begin
            if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (!grid_any) begin
            if (state_q == ST_ACC) begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_ACC) && (cur_q == grid_idx)) begin
            acc_d = acc_q | plate_s;
        end else begin
            commit  = (state_q == ST_ACC);
            state_d = ST_ACC;
            cur_d   = grid_idx;
            acc_d   = plate_s;
        end
    end

    // Commit fan-out, frame detection (grid 9 followed by grid 0) and read mux.
    always_comb begin
        commit_vec = '0;
        rd_mask_d  = '0;
        for (int n = 0; n < NGRID; n++) begin
            commit_vec[n] = commit && (cur_q == 4'(n));
            if (rd_grid == 4'(n)) rd_mask_d = mask_w[n];
        end
        frame_d = commit && (cur_q == 4'd0) && (last_q == 4'd9);
        last_d  = commit ? cur_q : last_q;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            acc_q     <= '0;
            glitch_q  <= '0;
            last_q    <= 4'hF;
            frame_q   <= 1'b0;
            pcnt_q    <= '0;
            rd_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            acc_q     <= acc_d;
            glitch_q  <= glitch_d;
            last_q    <= last_d;
            frame_q   <= frame_d;
            pcnt_q    <= pcnt_d;
            rd_mask_q <= rd_mask_d;
        end
    end

    for (genvar n = 0; n < NGRID; n++) begin : g_slot
        grid_slot #(.DECAY(DECAY)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .commit (commit_vec[n]),
            .tick   (tick),
            .acc    (acc_q),
            .mask   (mask_w[n])
        );
    end

    assign rd_mask      = rd_mask_q;
    assign frame_strobe = frame_q;
    assign glitch_cnt   = glitch_q;
    assign dbg_state    = (state_q == ST_ACC) ? {1'b1, cur_q} : 5'd0;

endmodule

// File: tb/tb_vfd_persist.sv
// Bench for vfd_persist: directed scenarios plus random scan traffic, all
// outputs compared each cycle against a behavioural model of the scan rules.
module tb_vfd_persist;

    localparam int TD = 4;
    localparam int DK = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  cur_grid  = '0;
    logic [16:0] cur_plate = '0;
    logic [3:0]  rd_grid   = '0;
    logic [3:0]  C, D, E, F, G, H;
    logic [2:0]  I;
    logic [16:0] rd_mask;
    logic        frame_strobe;
    logic [7:0]  glitch_cnt;
    logic [4:0]  dbg_state;

    assign C = cur_plate[3:0];
    assign D = cur_plate[7:4];
    assign E = cur_plate[11:8];
    assign F = cur_plate[15:12];
    assign G = {cur_plate[16], cur_grid[2:0]};
    assign H = cur_grid[6:3];
    assign I = cur_grid[9:7];

    vfd_persist #(.TICK_DIV(TD), .DECAY(DK)) dut (
        .clk          (clk),
        .reset        (rst),
        .C            (C),
        .D            (D),
        .E            (E),
        .F            (F),
        .G            (G),
        .H            (H),
        .I            (I),
        .rd_grid      (rd_grid),
        .rd_mask      (rd_mask),
        .frame_strobe (frame_strobe),
        .glitch_cnt   (glitch_cnt),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    bit fs_en    = 1'b0;
    int fs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0]  m_g1 = '0, m_g2 = '0;
    logic [16:0] m_p1 = '0, m_p2 = '0;
    int          m_cur = -1;
    logic [16:0] m_acc = '0;
    logic [16:0] m_mask [10];
    int          m_age [10];
    int          m_pcnt = 0;
    int          m_last = -1;
    int          m_glitch = 0;
    logic [16:0] m_rd = '0;
    bit          m_fs = 1'b0;

    always @(posedge clk) begin : model
        logic [9:0]  g;
        logic [16:0] p;
        logic [16:0] c_val;
        int          idx, c_idx;
        bit          do_c, tk;
        if (rst) begin
            m_g1 = '0; m_g2 = '0; m_p1 = '0; m_p2 = '0;
            m_cur = -1; m_acc = '0; m_pcnt = 0; m_last = -1;
            m_glitch = 0; m_rd = '0; m_fs = 1'b0;
            for (int n = 0; n < 10; n++) begin
                m_mask[n] = '0;
                m_age[n]  = DK;
            end
        end else begin
            m_rd = '0;
            for (int n = 0; n < 10; n++) if (rd_grid == n) m_rd = m_mask[n];
            g = m_g2; p = m_p2;
            do_c = 1'b0; c_idx = 0; c_val = '0;
            if ($countones(g) >= 2) begin
                if (m_glitch < 255) m_glitch++;
            end else if (g == 0) begin
                if (m_cur >= 0) begin
                    do_c = 1'b1; c_idx = m_cur; c_val = m_acc; m_cur = -1;
                end
            end else begin
                idx = 0;
                for (int k = 0; k < 10; k++) if (g[k]) idx = k;
                if (idx == m_cur) m_acc = m_acc | p;
                else begin
                    if (m_cur >= 0) begin
                        do_c = 1'b1; c_idx = m_cur; c_val = m_acc;
                    end
                    m_cur = idx;
                    m_acc = p;
                end
            end
            tk = (m_pcnt == TD - 1);
            m_pcnt = tk ? 0 : m_pcnt + 1;
            for (int n = 0; n < 10; n++) begin
                if (do_c && c_idx == n) begin
                    m_mask[n] = c_val;
                    m_age[n]  = 0;
                end else if (tk && m_age[n] < DK) begin
                    m_age[n]++;
                    if (m_age[n] == DK) m_mask[n] = '0;
                end
            end
            m_fs = do_c && (c_idx == 0) && (m_last == 9);
            if (do_c) m_last = c_idx;
            m_g2 = m_g1; m_p2 = m_p1;
            m_g1 = cur_grid; m_p1 = cur_plate;
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("rd_mask", 32'(rd_mask), 32'(m_rd));
            check("frame_strobe", 32'(frame_strobe), 32'(m_fs));
            check("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
            check("dbg_state", 32'(dbg_state), (m_cur >= 0) ? 32'(16 + m_cur) : 32'd0);
        end
    end

    always @(negedge clk) if (fs_en && frame_strobe) fs_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic strobe(input logic [9:0] g, input logic [16:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            cur_grid  = g;
            cur_plate = p;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        cur_grid = '0;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [16:0] rnd_plate();
        return 17'($urandom_range(0, 17'h1FFFF));
    endfunction

    // ---------------- stimulus ----------------
    int life;
    int a, b, kind, dur;
    logic [9:0] rg;

    initial begin
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        check("reset_rd_mask", 32'(rd_mask), 32'd0);
        check("reset_frame", 32'(frame_strobe), 32'd0);
        check("reset_glitch", 32'(glitch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(5);

        // grid 3 strobe with toggling plates, read after it ends
        rd_grid = 4'd3;
        for (int i = 0; i < 40; i++) begin
            cur_grid  = 10'h008;
            cur_plate = (i % 2 == 1) ? 17'h00100 : 17'h00001;
            @(negedge clk);
        end
        cur_grid = '0;
        repeat (4) @(posedge clk); #1;
        check("grid3_accum", 32'(rd_mask), 32'h00101);
        @(negedge clk);
        idle(3);

        // full scan 0..9 then 0 again: one frame pulse
        fs_count = 0;
        fs_en = 1'b1;
        for (int g = 0; g < 10; g++) strobe(10'(1) << g, rnd_plate(), 3);
        strobe(10'h001, rnd_plate(), 3);
        idle(8);
        fs_en = 1'b0;
        check("frame_count", 32'(fs_count), 32'd1);
        idle(20);

        // decay of grid 5 without refresh
        rd_grid = 4'd5;
        strobe(10'h020, 17'h1FFFF, 2);
        cur_grid = '0;
        repeat (3) @(posedge clk);
        life = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rd_mask == 17'h1FFFF) life++;
        end
        check("decay_life_in_5_to_8", 32'(life >= 5 && life <= 8), 32'd1);
        check("decay_end", 32'(rd_mask), 32'd0);
        @(negedge clk);
        idle(2);

        // refresh commit landing exactly on the clearing tick
        strobe(10'h020, 17'h1FFFF, 4);
        for (int k = 0; k < 8 && m_pcnt != 1; k++) @(negedge clk);
        if (m_pcnt != 1) begin
            n_checks++; n_errors++;
            $display("FAIL phase_align: got %0d expected 1", m_pcnt);
        end
        cur_grid = '0;
        @(negedge clk);
        strobe(10'h020, 17'h1FFFF, 7);
        cur_grid = '0;
        repeat (4) @(posedge clk); #1;
        check("refresh_on_clear", 32'(rd_mask), 32'h1FFFF);
        @(negedge clk);
        idle(3);

        // direct switch grid 2 -> grid 7
        rd_grid = 4'd2;
        strobe(10'h004, 17'h00003, 5);
        cur_grid  = 10'h080;
        cur_plate = 17'h10000;
        repeat (4) @(posedge clk); #1;
        check("switch_grid2", 32'(rd_mask), 32'h00003);
        @(negedge clk);
        rd_grid  = 4'd7;
        cur_grid = '0;
        repeat (4) @(posedge clk); #1;
        check("switch_grid7", 32'(rd_mask), 32'h10000);
        @(negedge clk);
        idle(3);

        // glitch storm inside ACC(6)
        strobe(10'h040, 17'h00050, 5);
        for (int i = 0; i < 300; i++) strobe(10'h003, rnd_plate(), 1);
        @(posedge clk); #1;
        check("glitch_sat", 32'(glitch_cnt), 32'd255);
        check("glitch_hold_state", 32'(dbg_state), 32'h16);
        @(negedge clk);
        strobe(10'h040, 17'h00050, 2);
        rd_grid  = 4'd6;
        cur_grid = '0;
        repeat (4) @(posedge clk); #1;
        check("grid6_after_glitch", 32'(rd_mask), 32'h00050);
        @(negedge clk);

        // random scan traffic
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 9);
            dur  = $urandom_range(1, 6);
            a    = $urandom_range(0, 9);
            b    = (a + 1 + $urandom_range(0, 8)) % 10;
            if (kind <= 2)      rg = '0;
            else if (kind <= 8) rg = 10'(1) << a;
            else                rg = (10'(1) << a) | (10'(1) << b);
            for (int i = 0; i < dur; i++) begin
                rd_grid = 4'($urandom_range(0, 15));
                strobe(rg, rnd_plate(), 1);
            end
        end

        // reset in the middle of ACC(4)
        idle(5);
        strobe(10'h010, 17'h0F0F0, 10);
        rst = 1'b1;
        cur_grid = '0;
        @(posedge clk); #1;
        check("midreset_rd_mask", 32'(rd_mask), 32'd0);
        check("midreset_frame", 32'(frame_strobe), 32'd0);
        check("midreset_glitch", 32'(glitch_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 16; g++) begin
            rd_grid = 4'(g);
            @(posedge clk); #1;
            check("post_reset_mask", 32'(rd_mask), 32'd0);
            @(negedge clk);
        end
        check("post_reset_glitch", 32'(glitch_cnt), 32'd0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vfd_persist.md
VFD_PERSIST -- requirements
Module: vfd_persist

Interface
REQ-001 Parameter TICK_DIV, default 20000, is the number of clk cycles per decay tick (1 ms at 20 MHz).
REQ-002 Parameter DECAY, default 8, is the number of ticks a grid's committed mask survives without a refresh strobe.
REQ-003 Port clk, input, 1: system clock (clk_sys domain); the block has one clock.
REQ-004 Port reset, input, 1: reset, asynchronous and active-high.
REQ-005 Ports C, D, E, F, G, H, input, 4 each: MCU output ports, asynchronous to clk.
REQ-006 Port I, input, 3: MCU output port, asynchronous to clk.
REQ-007 Port rd_grid, input, 4: grid index 0..9 requested by the downstream vfd renderer.
REQ-008 Port rd_mask, output, 17: committed plate mask for rd_grid.
REQ-009 Port frame_strobe, output, 1: one-cycle pulse at each completed scan frame.
REQ-010 Port glitch_cnt, output, 8: saturating count of multi-grid samples.

Function
REQ-011 Ports map as grid[9:0] = {I, H, G[2:0]} and plate[16:0] = {G[3], F, E, D, C}.
REQ-012 All 27 input bits pass through a two-flop synchronizer; all logic uses the synchronized values.
REQ-013 Sampled state decode: zero grid bits = IDLE; exactly one bit = ACTIVE(n); two or more = GLITCH.
REQ-014 FSM has states IDLE and ACC(n); the accumulator acc[16:0] holds the plates seen in the current strobe.
REQ-015 IDLE -> ACC(n) on ACTIVE(n); acc loads the current plate value.
REQ-016 In ACC(n) with ACTIVE(n) persisting, acc |= plate.
REQ-017 ACC(n) -> IDLE on IDLE: acc commits to mask[n], age[n] resets to 0.
REQ-018 ACC(n) -> ACC(m), m != n: mask[n] commits and acc reloads with plate in the same cycle.
REQ-019 A GLITCH sample is ignored: no state change, no acc update, glitch_cnt increments and saturates at 255.
REQ-020 A prescaler counts 0..TICK_DIV-1 and wraps; at wrap, every age[n] below DECAY increments.
REQ-021 When age[n] reaches DECAY, mask[n] clears to 0 in that same tick cycle.
REQ-022 If a commit and a tick hit the same grid in one cycle, the commit wins (age = 0, mask = acc).
REQ-023 frame_strobe pulses on the commit cycle of grid 0 when the previous commit was grid 9.
REQ-024 rd_mask is registered with one cycle of latency after rd_grid.
REQ-025 rd_grid values 10..15 return all zeros.
REQ-026 Committed masks change only on commit or decay and never reflect a partial accumulation.

Reset
REQ-027 Reset clears the synchronizers, acc, all mask[n], and the prescaler, and sets state to IDLE.
REQ-028 Reset sets all age[n] = DECAY, so every grid reads as decayed.
REQ-029 During reset, rd_mask = 0, frame_strobe = 0, and glitch_cnt = 0.
REQ-030 Reset asserted mid-accumulation discards acc without committing.
REQ-031 After reset deasserts, the first valid commit is on the third clk edge after the ports become stable.

Structure
REQ-032 Shared package vfd_pkg holds NGRID = 10, NPLATE = 17, the grid/plate port-mapping functions and the FSM state enum; vfd (the downstream renderer) imports the same package.
REQ-033 One sub-module, grid_slot, holds mask[n] and age[n] with inputs commit, tick and acc; vfd_persist instantiates it NGRID times.
REQ-034 The prescaler, FSM, synchronizer and read mux reside in vfd_persist.

Verification
REQ-035 Strobe grid 3 for 40 cycles with plate toggling 0x00001/0x00100, then idle; after sync latency plus 1 cycle, rd_grid = 3 -> rd_mask = 0x00101.
REQ-036 Scan grids 0..9 in sequence, then grid 0 again -> exactly one frame_strobe, on the grid 0 commit cycle.
REQ-037 With TICK_DIV = 4 and DECAY = 2, commit grid 5 = 0x1FFFF with no refresh -> rd_mask for grid 5 becomes 0 at the second prescaler wrap; a refresh landing on the clearing cycle keeps 0x1FFFF.
REQ-038 Drive grid = 0x003 for 300 cycles -> glitch_cnt = 255, no mask changes, FSM remains in its prior state.
REQ-039 Direct switch from grid 2 to grid 7 with no idle gap -> grid 2 commits its mask and grid 7 accumulates from the switch cycle.
REQ-040 Assert reset during ACC(4) with acc = 0x0F0F0 -> after reset, rd_mask = 0 for every grid and glitch_cnt = 0.
